// File: rtl/mdu_controller.sv
// Multiply/divide unit for the E stage: owns HI/LO, sequences MULT/DIV with a
// busy counter that models real latency, and requests stalls for later MDU ops.
module mdu_controller #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] MDU_i_Operand1,
    input  logic [31:0] MDU_i_Operand2,
    input  logic [3:0]  MDU_i_Operation,
    input  logic        MDU_i_Start,
    input  logic        MDU_i_isMDInstr,
    input  logic        MDU_i_ReadHI,
    output logic [31:0] MDU_o_ReadData,
    output logic        MDU_o_Busy,
    output logic        MDU_o_Stall,
    output logic [31:0] MDU_o_HI,
    output logic [31:0] MDU_o_LO
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    typedef enum logic {S_IDLE, S_RUN} state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] opa_q, opa_d;
    logic [31:0] opb_q, opb_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;

    logic        start_long;
    logic        retire;
    logic [63:0] prod_s, prod_u;
    logic        a_neg, b_neg, div_by_zero;
    logic [31:0] mag_a, mag_b, div_den;
    logic [31:0] quo_u, rem_u, quo, rem;

    assign start_long = MDU_i_Start &&
                        (MDU_i_Operation >= OP_MULT) && (MDU_i_Operation <= OP_DIVU);
    assign retire     = (state_q == S_RUN) && (cnt_q == 4'd1);

    // Results are formed from the latched operands; only the retire edge uses them.
    always_comb begin
        prod_s = $signed({{32{opa_q[31]}}, opa_q}) * $signed({{32{opb_q[31]}}, opb_q});
        prod_u = {32'd0, opa_q} * {32'd0, opb_q};
    end

    // Signed divide via magnitudes so INT_MIN / -1 wraps to INT_MIN instead of trapping.
    always_comb begin
        a_neg       = (op_q == OP_DIV) && opa_q[31];
        b_neg       = (op_q == OP_DIV) && opb_q[31];
        mag_a       = a_neg ? (~opa_q + 32'd1) : opa_q;
        mag_b       = b_neg ? (~opb_q + 32'd1) : opb_q;
        div_by_zero = (opb_q == 32'd0);
        div_den     = div_by_zero ? 32'd1 : mag_b;
        quo_u       = mag_a / div_den;
        rem_u       = mag_a % div_den;
        quo         = (a_neg ^ b_neg) ? (~quo_u + 32'd1) : quo_u;
        rem         = a_neg ? (~rem_u + 32'd1) : rem_u;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 4'd0;
            opa_q   <= 32'd0;
            opb_q   <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_long) state_d = S_RUN;
            S_RUN:   if (cnt_q == 4'd1) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Start is only honoured in IDLE; a strobe arriving during RUN is dropped.
    always_comb begin
        cnt_d = cnt_q;
        op_d  = op_q;
        opa_d = opa_q;
        opb_d = opb_q;
        hi_d  = hi_q;
        lo_d  = lo_q;
        if (state_q == S_IDLE) begin
            if (MDU_i_Start) begin
                case (MDU_i_Operation)
                    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                        cnt_d = (MDU_i_Operation <= OP_MULTU) ? MULT_LOAD : DIV_LOAD;
                        op_d  = MDU_i_Operation;
                        opa_d = MDU_i_Operand1;
                        opb_d = MDU_i_Operand2;
                    end
                    OP_MTHI: hi_d = MDU_i_Operand1;
                    OP_MTLO: lo_d = MDU_i_Operand1;
                    default: ;
                endcase
            end
        end else begin
            cnt_d = cnt_q - 4'd1;
            if (retire) begin
                case (op_q)
                    OP_MULT:  {hi_d, lo_d} = prod_s;
                    OP_MULTU: {hi_d, lo_d} = prod_u;
                    OP_DIV, OP_DIVU: begin
                        if (!div_by_zero) begin
                            hi_d = rem;
                            lo_d = quo;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_comb begin
        MDU_o_Busy     = (state_q == S_RUN);
        MDU_o_Stall    = MDU_i_isMDInstr && ((state_q == S_RUN) || start_long);
        MDU_o_ReadData = MDU_i_ReadHI ? hi_q : lo_q;
        MDU_o_HI       = hi_q;
        MDU_o_LO       = lo_q;
    end

endmodule
